// File: rtl/photo_reader_emu.sv
// photo_reader_emu: G-15 photoelectric tape reader emulator; buffers a loaded
// 5-channel tape image and replays it frame by frame under FWD/REV motion commands.
module photo_reader_emu #(
    parameter int DEPTH    = 4096,
    parameter int ADDR_W   = 12,
    parameter int HOLD_CYC = 64,
    parameter int GAP_CYC  = 64
) (
    input  logic              CLOCK,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [4:0]        load_data,
    input  logic              load_last,
    input  logic              tape_clear,
    input  logic              rewind,
    input  logic              PHOTO_READER_FWD,
    input  logic              PHOTO_READER_REV,
    output logic              PHOTO_READER_PERMIT,
    output logic              PL6_PHOTO1,
    output logic              PL6_PHOTO2,
    output logic              PL6_PHOTO3,
    output logic              PL6_PHOTO4,
    output logic              PL6_PHOTO5,
    output logic [ADDR_W:0]   tape_pos,
    output logic              at_start,
    output logic              at_end
);
    localparam int CW = $clog2(HOLD_CYC > GAP_CYC ? HOLD_CYC : GAP_CYC);

    typedef enum logic [2:0] {EMPTY, LOADING, IDLE, FETCH, HOLD, GAP} state_t;

    state_t            state, state_n;
    logic [ADDR_W:0]   len, len_n, pos, pos_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              dir, dir_n;
    logic [4:0]        photo, photo_n, rdata;
    logic [4:0]        mem [DEPTH];
    logic [ADDR_W-1:0] raddr;
    logic              accept, cmd_f, cmd_r, can_f, can_r;

    assign load_ready = state == EMPTY || state == LOADING;
    assign accept     = load_valid & load_ready;
    assign cmd_f      = PHOTO_READER_FWD & ~PHOTO_READER_REV;
    assign cmd_r      = PHOTO_READER_REV & ~PHOTO_READER_FWD;
    assign at_start   = pos == '0;
    assign at_end     = pos == len;
    assign can_f      = cmd_f & ~at_end;
    assign can_r      = cmd_r & ~at_start;
    assign tape_pos   = pos;
    assign {PL6_PHOTO5, PL6_PHOTO4, PL6_PHOTO3, PL6_PHOTO2, PL6_PHOTO1} = photo;
    // dir=1 means reverse: the frame behind the head is mem[pos-1]
    assign raddr      = dir_n ? ADDR_W'(pos - 1'b1) : pos[ADDR_W-1:0];

    always_comb begin
        state_n = state;
        len_n   = len;
        pos_n   = pos;
        cnt_n   = cnt;
        dir_n   = dir;
        photo_n = photo;
        if (tape_clear) begin
            state_n = EMPTY;
            len_n   = '0;
            pos_n   = '0;
            photo_n = '0;
        end else begin
            case (state)
                EMPTY, LOADING: if (accept) begin
                    len_n   = len + 1'b1;
                    state_n = (load_last || len == (ADDR_W+1)'(DEPTH-1)) ? IDLE : LOADING;
                end
                IDLE: if (rewind) pos_n = '0;
                    else if (can_f || can_r) begin
                        state_n = FETCH;
                        dir_n   = can_r;
                    end
                FETCH: begin
                    photo_n = rdata;
                    pos_n   = dir ? pos - 1'b1 : pos + 1'b1;
                    cnt_n   = CW'(HOLD_CYC-1);
                    state_n = HOLD;
                end
                HOLD: if (cnt == '0) begin
                    photo_n = '0;
                    cnt_n   = CW'(GAP_CYC-1);
                    state_n = GAP;
                end else cnt_n = cnt - 1'b1;
                GAP: if (cnt == '0) state_n = (dir ? can_r : can_f) ? FETCH : IDLE;
                    else cnt_n = cnt - 1'b1;
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            state               <= EMPTY;
            len                 <= '0;
            pos                 <= '0;
            cnt                 <= '0;
            dir                 <= 1'b0;
            photo               <= '0;
            PHOTO_READER_PERMIT <= 1'b0;
        end else begin
            state               <= state_n;
            len                 <= len_n;
            pos                 <= pos_n;
            cnt                 <= cnt_n;
            dir                 <= dir_n;
            photo               <= photo_n;
            PHOTO_READER_PERMIT <= state_n inside {IDLE, FETCH, HOLD, GAP};
        end
    end

    always_ff @(posedge CLOCK) begin
        if (accept && !tape_clear) mem[len[ADDR_W-1:0]] <= load_data;
        rdata <= mem[raddr];
    end
endmodule

// File: tb/tb_photo_reader_emu.sv
// tb_photo_reader_emu: directed checks of load, forward/reverse replay, limits,
// overflow, tape_clear and asynchronous reset of the tape reader emulator.
module tb_photo_reader_emu;
    localparam int DEPTH = 16, AW = 4, H = 4, G = 2;

    logic          CLOCK = 0, rst = 0;
    logic          load_valid = 0, load_last = 0, tape_clear = 0, rewind = 0;
    logic          fwd = 0, rev = 0;
    logic [4:0]    load_data = 0;
    logic          load_ready, permit, p1, p2, p3, p4, p5, at_start, at_end;
    logic [AW:0]   tape_pos;
    logic [4:0]    ph;
    int            n_chk = 0, n_pass = 0, acc;

    assign ph = {p5, p4, p3, p2, p1};

    photo_reader_emu #(.DEPTH(DEPTH), .ADDR_W(AW), .HOLD_CYC(H), .GAP_CYC(G)) dut (
        .CLOCK(CLOCK), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last),
        .tape_clear(tape_clear), .rewind(rewind),
        .PHOTO_READER_FWD(fwd), .PHOTO_READER_REV(rev),
        .PHOTO_READER_PERMIT(permit),
        .PL6_PHOTO1(p1), .PL6_PHOTO2(p2), .PL6_PHOTO3(p3), .PL6_PHOTO4(p4), .PL6_PHOTO5(p5),
        .tape_pos(tape_pos), .at_start(at_start), .at_end(at_end)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic load(input logic [4:0] d, input logic last);
        load_valid = 1; load_data = d; load_last = last;
        @(negedge CLOCK);
        load_valid = 0; load_last = 0;
    endtask

    // One frame period seen from the FETCH cycle: 1 fetch, H hold, G gap
    task automatic frame(input string tag, input logic [4:0] f);
        for (int k = 0; k < 1 + H + G; k++) begin
            @(negedge CLOCK);
            chk(tag, 32'(ph), (k >= 1 && k <= H) ? 32'(f) : 32'd0);
        end
    endtask

    initial begin
        #2;
        chk("rst_photo", 32'(ph), 0);
        chk("rst_permit", 32'(permit), 0);
        chk("rst_pos", 32'(tape_pos), 0);
        chk("rst_at_start", 32'(at_start), 1);
        chk("rst_at_end", 32'(at_end), 1);
        chk("rst_ready", 32'(load_ready), 1);
        @(negedge CLOCK); rst = 1;

        // test 1: load and forward replay
        load(5'h01, 0);
        chk("loading_ready", 32'(load_ready), 1);
        chk("loading_permit", 32'(permit), 0);
        load(5'h1F, 0);
        load(5'h10, 1);
        chk("idle_permit", 32'(permit), 1);
        chk("idle_ready", 32'(load_ready), 0);
        chk("idle_at_end", 32'(at_end), 0);
        fwd = 1;
        frame("fwd_f0", 5'h01);
        frame("fwd_f1", 5'h1F);
        frame("fwd_f2", 5'h10);
        repeat (3) begin
            @(negedge CLOCK);
            chk("fwd_limit_photo", 32'(ph), 0);
        end
        chk("fwd_end_pos", 32'(tape_pos), 3);
        chk("fwd_at_end", 32'(at_end), 1);
        chk("fwd_permit", 32'(permit), 1);

        // test 2: reverse replay
        fwd = 0; rev = 1;
        frame("rev_f2", 5'h10);
        frame("rev_f1", 5'h1F);
        frame("rev_f0", 5'h01);
        @(negedge CLOCK);
        chk("rev_limit_photo", 32'(ph), 0);
        chk("rev_pos", 32'(tape_pos), 0);
        chk("rev_at_start", 32'(at_start), 1);

        // test 3: drop FWD mid-HOLD
        rev = 0; fwd = 1;
        @(negedge CLOCK); chk("drop_fetch", 32'(ph), 0);
        @(negedge CLOCK); chk("drop_hold", 32'(ph), 5'h01);
        fwd = 0;
        for (int k = 2; k < 1 + H + G; k++) begin
            @(negedge CLOCK);
            chk("drop_rest", 32'(ph), (k <= H) ? 32'h01 : 32'd0);
        end
        repeat (2) begin
            @(negedge CLOCK);
            chk("drop_stopped", 32'(ph), 0);
        end
        chk("drop_pos", 32'(tape_pos), 1);
        rewind = 1;
        @(negedge CLOCK); rewind = 0;
        chk("rewind_pos", 32'(tape_pos), 0);

        // test 4: overflow load
        tape_clear = 1;
        @(negedge CLOCK); tape_clear = 0;
        chk("clr_ready", 32'(load_ready), 1);
        chk("clr_permit", 32'(permit), 0);
        acc = 0;
        load_valid = 1;
        for (int i = 0; i < DEPTH + 5; i++) begin
            load_data = 5'(i + 1);
            if (load_ready) acc++;
            @(negedge CLOCK);
            if (i == DEPTH - 2) chk("ovf_ready_before", 32'(load_ready), 1);
            if (i == DEPTH - 1) chk("ovf_ready_fall", 32'(load_ready), 0);
        end
        load_valid = 0;
        chk("ovf_accepted", 32'(acc), DEPTH);
        chk("ovf_permit", 32'(permit), 1);
        chk("ovf_at_end", 32'(at_end), 0);

        // test 5: both commands, then tape_clear mid-HOLD
        fwd = 1; rev = 1;
        repeat (3) begin
            @(negedge CLOCK);
            chk("both_photo", 32'(ph), 0);
        end
        chk("both_pos", 32'(tape_pos), 0);
        rev = 0;
        @(negedge CLOCK); chk("clr_fetch", 32'(ph), 0);
        @(negedge CLOCK); chk("clr_hold", 32'(ph), 5'h01);
        tape_clear = 1;
        @(negedge CLOCK); tape_clear = 0; fwd = 0;
        chk("clr_photo", 32'(ph), 0);
        chk("clr_permit2", 32'(permit), 0);
        chk("clr_ready2", 32'(load_ready), 1);
        chk("clr_pos", 32'(tape_pos), 0);

        // test 6: async reset mid-HOLD
        load(5'h1F, 0);
        load(5'h03, 1);
        fwd = 1;
        @(negedge CLOCK); chk("ar_fetch", 32'(ph), 0);
        @(negedge CLOCK); chk("ar_hold", 32'(ph), 5'h1F);
        #2 rst = 0;
        #1;
        chk("ar_photo", 32'(ph), 0);
        chk("ar_pos", 32'(tape_pos), 0);
        chk("ar_permit", 32'(permit), 0);
        chk("ar_ready", 32'(load_ready), 1);
        fwd = 0;
        @(negedge CLOCK); rst = 1;
        @(negedge CLOCK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
